cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: opcode  input  3  instruction-register opcode field (HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111).
REQ-004 SHALL have port: zero  input  1  accumulator-is-zero flag.
REQ-005 SHALL have port: mem_ready  input  1  memory access complete this cycle.
REQ-006 SHALL have ports: sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e  output  1 each  address-mux select (1=PC, 0=IR operand), memory read, memory write, IR load, ACC load, PC load, PC increment, ACC-to-bus drive.
REQ-007 SHALL have port: halt  output  1  CPU halted.
REQ-008 SHALL have port: phase  output  3  current phase encoding, for debug.
REQ-009 SHALL have port: instr_done  output  1  one-cycle pulse on the cycle an instruction retires.

Function
REQ-010 SHALL sequence nine states: ADDR(0), FETCH(1), LOAD_IR(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU(6), STORE(7), HALTED (phase output 7, halt=1).
REQ-011 SHALL advance one state per clock, ADDR through STORE, then wrap STORE->ADDR, except where REQ-012..014 stall or redirect.
REQ-012 SHALL hold FETCH until mem_ready=1; FETCH->LOAD_IR on the cycle mem_ready=1.
REQ-013 SHALL, in OP_FETCH with ALUOP (ADD/AND/XOR/LDA), hold until mem_ready=1; with STO, hold STORE until mem_ready=1; other opcodes SHALL not wait.
REQ-014 SHALL go OP_ADDR->HALTED when opcode=HLT; HALTED SHALL be left only by rst.
REQ-015 SHALL decode outputs combinationally from the current state, opcode and zero; unlisted outputs are 0.
- ADDR: sel.
- FETCH, LOAD_IR: sel, rd; LOAD_IR adds ld_ir.
- IDLE: sel, rd.
- OP_ADDR: inc_pc.
- OP_FETCH: rd=ALUOP.
- ALU: rd=ALUOP; inc_pc=(SKZ & zero); ld_pc=JMP; data_e=STO.
- STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=JMP; wr=STO; data_e=STO.
- HALTED: halt=1, all others 0.
REQ-016 SHALL pulse instr_done for exactly one cycle when leaving STORE; it SHALL not pulse on entry to HALTED.
REQ-017 SHALL assert inc_pc at most twice per instruction, namely at OP_ADDR and, on SKZ with zero=1, at ALU.
REQ-018 SHALL never assert rd and wr in the same cycle; wr SHALL never assert without data_e.
REQ-019 SHALL sample zero only in ALU; changes of zero in other states have no effect.
REQ-020 SHALL treat opcode as stable from LOAD_IR+1 through STORE; it SHALL not latch opcode internally.
REQ-021 SHALL make minimum instruction latency 8 cycles with zero wait states; each mem_ready=0 cycle in a waiting state adds one cycle.

Reset
REQ-022 SHALL, on rst=1 at a rising edge, enter ADDR regardless of current state, including a mid-wait or HALTED state.
REQ-023 SHALL, in the cycle after reset, present the ADDR decode: sel=1, all other outputs 0, halt=0, phase=0, instr_done=0.
REQ-024 SHALL let rst override mem_ready and opcode on the same edge.

Structure
REQ-025 SHALL take opcode constants and the state/phase encoding from the shared CPU package, which the instruction decoder also uses.
REQ-026 SHALL be a single module (a registered state plus a combinational decode); no sub-module.

Verification
REQ-027 Bench SHALL cover: reset, then LDA, mem_ready tied to 1 -> phases 0..7 in 8 cycles; rd=1 in OP_FETCH/ALU/STORE; ld_ac=1 only in STORE; instr_done pulse at the STORE->ADDR transition.
REQ-028 Bench SHALL cover: FETCH with mem_ready=0 for 3 cycles -> phase stays 1 for 4 cycles, ld_ir deferred by 3; total latency 11.
REQ-029 Bench SHALL cover: SKZ with zero=1 -> inc_pc high in OP_ADDR and ALU (2 pulses); SKZ with zero=0 -> 1 pulse.
REQ-030 Bench SHALL cover: STO with mem_ready=0 for 2 STORE cycles -> wr=data_e=1 for 3 cycles, rd=0 throughout.
REQ-031 Bench SHALL cover: HLT -> halt=1 from the cycle after OP_ADDR, held for 20 cycles, no instr_done; rst=1 -> phase=0, halt=0.
REQ-032 Bench SHALL cover: rst asserted during OP_FETCH wait -> next cycle phase=0, sel=1, rd=0, wr=0.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer_pkg
// Purpose  : Shared CPU definitions: opcode encoding, sequencer state and
//            phase encoding, control-word layout and small decode helpers.
//            Used by the sequencer and the instruction decoder.
// Revision : 1.0  initial release
// ============================================================================
package cpu_sequencer_pkg;

  // Instruction-register opcode field
  typedef enum logic [2:0] {
    OP_HLT = 3'b000,
    OP_SKZ = 3'b001,
    OP_ADD = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_LDA = 3'b101,
    OP_STO = 3'b110,
    OP_JMP = 3'b111
  } opcode_e;

  // Sequencer states. The eight active states use their phase number as
  // their encoding; HALTED needs a ninth code and so a fourth state bit.
  typedef enum logic [3:0] {
    ST_ADDR     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_LOAD_IR  = 4'd2,
    ST_IDLE     = 4'd3,
    ST_OP_ADDR  = 4'd4,
    ST_OP_FETCH = 4'd5,
    ST_ALU      = 4'd6,
    ST_STORE    = 4'd7,
    ST_HALTED   = 4'd8
  } state_e;

  localparam int unsigned PHASE_W      = 3;
  // HALTED shares phase code 7 with STORE; the halt output tells them apart.
  localparam logic [PHASE_W-1:0] PHASE_HALTED = 3'd7;

  // One bit per sequencer control output
  typedef struct packed {
    logic sel;
    logic rd;
    logic wr;
    logic ld_ir;
    logic ld_ac;
    logic ld_pc;
    logic inc_pc;
    logic data_e;
    logic halt;
  } ctrl_t;

  // Opcodes whose operand is read from memory and written into the ACC
  function automatic logic is_aluop(opcode_e op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

  // Debug phase code for a state
  function automatic logic [PHASE_W-1:0] phase_of(state_e s);
    logic [PHASE_W-1:0] p;
    case (s)
      ST_HALTED: p = PHASE_HALTED;
      default:   p = s[PHASE_W-1:0];
    endcase
    return p;
  endfunction

endpackage : cpu_sequencer_pkg
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer
// Purpose  : Eight-phase instruction sequencer for the accumulator CPU.
//            A registered state plus a combinational control decode; memory
//            wait states stretch FETCH, OP_FETCH and STORE, and HLT parks the
//            machine in HALTED until reset.
// Revision : 1.0  initial release
// ============================================================================
module cpu_sequencer
  import cpu_sequencer_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   opcode,
  input  logic         zero,
  input  logic         mem_ready,
  output logic         sel,
  output logic         rd,
  output logic         wr,
  output logic         ld_ir,
  output logic         ld_ac,
  output logic         ld_pc,
  output logic         inc_pc,
  output logic         data_e,
  output logic         halt,
  output logic [2:0]   phase,
  output logic         instr_done
);

  state_e  state_q;
  state_e  state_d;
  opcode_e op;
  ctrl_t   ctrl;

  logic    op_alu;
  logic    op_sto;
  logic    fetch_stall;
  logic    opfetch_stall;
  logic    store_stall;

  // Opcode comes straight from the IR; it is stable from IDLE to STORE.
  assign op     = opcode_e'(opcode);
  assign op_alu = is_aluop(op);
  assign op_sto = (op == OP_STO);

  // Wait conditions: only memory-touching states hold for mem_ready
  assign fetch_stall   = !mem_ready;
  assign opfetch_stall = op_alu && !mem_ready;
  assign store_stall   = op_sto && !mem_ready;

  // State register; reset wins over every other input on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ADDR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: advance one phase per clock unless stalled or halting
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ADDR:     state_d = ST_FETCH;
      ST_FETCH:    state_d = fetch_stall ? ST_FETCH : ST_LOAD_IR;
      ST_LOAD_IR:  state_d = ST_IDLE;
      ST_IDLE:     state_d = ST_OP_ADDR;
      ST_OP_ADDR:  state_d = (op == OP_HLT) ? ST_HALTED : ST_OP_FETCH;
      ST_OP_FETCH: state_d = opfetch_stall ? ST_OP_FETCH : ST_ALU;
      ST_ALU:      state_d = ST_STORE;
      ST_STORE:    state_d = store_stall ? ST_STORE : ST_ADDR;
      ST_HALTED:   state_d = ST_HALTED;
      // Unused encodings recover to the start of an instruction
      default:     state_d = ST_ADDR;
    endcase
  end

  // Control decode from current state, opcode and (in ALU only) zero
  always_comb begin
    ctrl = '0;
    case (state_q)
      ST_ADDR: begin
        ctrl.sel = 1'b1;
      end
      ST_FETCH: begin
        ctrl.sel = 1'b1;
        ctrl.rd  = 1'b1;
      end
      ST_LOAD_IR: begin
        ctrl.sel   = 1'b1;
        ctrl.rd    = 1'b1;
        ctrl.ld_ir = 1'b1;
      end
      ST_IDLE: begin
        ctrl.sel = 1'b1;
        ctrl.rd  = 1'b1;
      end
      ST_OP_ADDR: begin
        ctrl.inc_pc = 1'b1;
      end
      ST_OP_FETCH: begin
        ctrl.rd = op_alu;
      end
      ST_ALU: begin
        ctrl.rd     = op_alu;
        // Skip the next instruction when SKZ sees a zero accumulator
        ctrl.inc_pc = (op == OP_SKZ) && zero;
        ctrl.ld_pc  = (op == OP_JMP);
        // Drive the ACC onto the bus one cycle ahead of the write strobe
        ctrl.data_e = op_sto;
      end
      ST_STORE: begin
        ctrl.rd     = op_alu;
        ctrl.ld_ac  = op_alu;
        ctrl.ld_pc  = (op == OP_JMP);
        ctrl.wr     = op_sto;
        ctrl.data_e = op_sto;
      end
      ST_HALTED: begin
        ctrl.halt = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

  assign sel    = ctrl.sel;
  assign rd     = ctrl.rd;
  assign wr     = ctrl.wr;
  assign ld_ir  = ctrl.ld_ir;
  assign ld_ac  = ctrl.ld_ac;
  assign ld_pc  = ctrl.ld_pc;
  assign inc_pc = ctrl.inc_pc;
  assign data_e = ctrl.data_e;
  assign halt   = ctrl.halt;
  assign phase  = phase_of(state_q);

  // Retire on the last STORE cycle; a reset on that edge cancels the retire
  assign instr_done = (state_q == ST_STORE) && !store_stall && !rst;

endmodule : cpu_sequencer
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_sequencer
// Purpose  : Self-checking bench for cpu_sequencer. Stimulus records carry
//            the per-cycle inputs and the expected outputs derived from the
//            phase/decode table; expectations are queued when a cycle is
//            driven and compared once the outputs have settled.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_sequencer;

  localparam logic [2:0] C_HLT = 3'b000;
  localparam logic [2:0] C_SKZ = 3'b001;
  localparam logic [2:0] C_ADD = 3'b010;
  localparam logic [2:0] C_AND = 3'b011;
  localparam logic [2:0] C_XOR = 3'b100;
  localparam logic [2:0] C_LDA = 3'b101;
  localparam logic [2:0] C_STO = 3'b110;
  localparam logic [2:0] C_JMP = 3'b111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] opcode = 3'b000;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, instr_done;
  logic [2:0] phase;

  cpu_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .sel        (sel),
    .rd         (rd),
    .wr         (wr),
    .ld_ir      (ld_ir),
    .ld_ac      (ld_ac),
    .ld_pc      (ld_pc),
    .inc_pc     (inc_pc),
    .data_e     (data_e),
    .halt       (halt),
    .phase      (phase),
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus and its expected output vector
  typedef struct packed {
    logic        rst;
    logic [2:0]  op;
    logic        z;
    logic        mr;
    logic        chk;
    logic [12:0] exp;
  } cyc_t;

  cyc_t        stim_q[$];
  logic [12:0] sb_q[$];

  int  n_vec = 0;
  int  n_bad = 0;
  bit  tie_mr = 1'b0;

  // Per-run observations
  int  n_cyc, n_inc, n_wrde, n_ldac, n_done, n_halt, n_viol, done_at;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected vector {halt,instr_done,phase,sel,rd,wr,ld_ir,ld_ac,ld_pc,inc_pc,data_e}
  // p = 0..7 active phases, 8 = HALTED
  function automatic logic [12:0] ev(int p, logic [2:0] op, logic z, logic done);
    logic alu, sto, jmp;
    logic [2:0] ph;
    alu = (op == C_ADD) || (op == C_AND) || (op == C_XOR) || (op == C_LDA);
    sto = (op == C_STO);
    jmp = (op == C_JMP);
    ph  = (p == 8) ? 3'd7 : 3'(p);
    return { (p == 8), done, ph,
             (p <= 3),
             ((p >= 1 && p <= 3) || ((p >= 5 && p <= 7) && alu)),
             (p == 7 && sto),
             (p == 2),
             (p == 7 && alu),
             ((p == 6 || p == 7) && jmp),
             (p == 4 || (p == 6 && op == C_SKZ && z)),
             ((p == 6 || p == 7) && sto) };
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic rmr();
    return tie_mr ? 1'b1 : rb();
  endfunction

  function automatic logic [2:0] rop();
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic push(input logic r, input logic [2:0] op, input logic z,
                      input logic mr, input logic c, input int p, input logic done);
    cyc_t x;
    x.rst = r; x.op = op; x.z = z; x.mr = mr; x.chk = c;
    x.exp = ev(p, op, z, done);
    stim_q.push_back(x);
  endtask

  // ADDR .. OP_ADDR; opcode is a don't-care until LOAD_IR has loaded it
  task automatic gen_front(input logic [2:0] op, input int fw);
    push(1'b0, rop(), rb(), rmr(), 1'b1, 0, 1'b0);
    for (int i = 0; i < fw; i++) push(1'b0, rop(), rb(), 1'b0, 1'b1, 1, 1'b0);
    push(1'b0, rop(), rb(), 1'b1, 1'b1, 1, 1'b0);
    push(1'b0, rop(), rb(), rmr(), 1'b1, 2, 1'b0);
    push(1'b0, op, rb(), rmr(), 1'b1, 3, 1'b0);
    push(1'b0, op, rb(), rmr(), 1'b1, 4, 1'b0);
  endtask

  // One whole instruction; fw = FETCH waits, ow = OP_FETCH/STORE waits,
  // hold = HALTED cycles after an HLT
  task automatic gen_instr(input logic [2:0] op, input logic z, input int fw,
                           input int ow, input int hold);
    logic alu;
    alu = (op == C_ADD) || (op == C_AND) || (op == C_XOR) || (op == C_LDA);
    gen_front(op, fw);
    if (op == C_HLT) begin
      for (int i = 0; i < hold; i++) push(1'b0, rop(), rb(), rb(), 1'b1, 8, 1'b0);
    end else begin
      if (alu) begin
        for (int i = 0; i < ow; i++) push(1'b0, op, rb(), 1'b0, 1'b1, 5, 1'b0);
        push(1'b0, op, rb(), 1'b1, 1'b1, 5, 1'b0);
      end else begin
        push(1'b0, op, rb(), rmr(), 1'b1, 5, 1'b0);
      end
      push(1'b0, op, z, rmr(), 1'b1, 6, 1'b0);
      if (op == C_STO) begin
        for (int i = 0; i < ow; i++) push(1'b0, op, rb(), 1'b0, 1'b1, 7, 1'b0);
        push(1'b0, op, rb(), 1'b1, 1'b1, 7, 1'b1);
      end else begin
        push(1'b0, op, rb(), rmr(), 1'b1, 7, 1'b1);
      end
    end
  endtask

  // Drain the stimulus queue, scoring every checked cycle
  task automatic run_q(input string tag);
    cyc_t        c;
    logic [12:0] obs;
    logic [12:0] e;
    n_cyc = 0; n_inc = 0; n_wrde = 0; n_ldac = 0;
    n_done = 0; n_halt = 0; n_viol = 0; done_at = 0;
    while (stim_q.size() > 0) begin
      @(negedge clk);
      c = stim_q.pop_front();
      rst = c.rst; opcode = c.op; zero = c.z; mem_ready = c.mr;
      if (c.chk) sb_q.push_back(c.exp);
      #1;
      obs = {halt, instr_done, phase, sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e};
      n_cyc++;
      n_inc  += int'(inc_pc);
      n_wrde += int'(wr && data_e);
      n_ldac += int'(ld_ac);
      n_halt += int'(halt);
      n_viol += int'((rd && wr) || (wr && !data_e));
      if (instr_done) begin
        n_done++;
        if (done_at == 0) done_at = n_cyc;
      end
      if (c.chk) begin
        e = sb_q.pop_front();
        chk($sformatf("%s.c%0d", tag, n_cyc), 32'(obs), 32'(e));
      end
    end
  endtask

  initial begin
    // Reset: first cycle state is unknown, second must show the ADDR decode
    push(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    push(1'b1, rop(), rb(), rb(), 1'b1, 0, 1'b0);
    run_q("reset");

    // LDA with mem_ready tied high: 8-cycle instruction
    tie_mr = 1'b1;
    gen_instr(C_LDA, 1'b0, 0, 0, 0);
    run_q("lda");
    chk("lda_latency", 32'(done_at), 32'd8);
    chk("lda_ld_ac",   32'(n_ldac),  32'd1);
    chk("lda_done",    32'(n_done),  32'd1);
    tie_mr = 1'b0;

    // FETCH held for 3 wait cycles
    gen_instr(C_LDA, 1'b0, 3, 0, 0);
    run_q("lda_fw3");
    chk("fw3_latency", 32'(done_at), 32'd11);

    // SKZ with zero set and clear
    gen_instr(C_SKZ, 1'b1, 0, 0, 0);
    run_q("skz1");
    chk("skz1_inc", 32'(n_inc), 32'd2);
    gen_instr(C_SKZ, 1'b0, 0, 0, 0);
    run_q("skz0");
    chk("skz0_inc", 32'(n_inc), 32'd1);

    // STO with 2 STORE wait cycles
    gen_instr(C_STO, 1'b0, 0, 2, 0);
    run_q("sto");
    chk("sto_wr_de",   32'(n_wrde),  32'd3);
    chk("sto_latency", 32'(done_at), 32'd10);
    chk("sto_rd_wr",   32'(n_viol),  32'd0);

    // Mixed stream with operand waits
    gen_instr(C_ADD, 1'b0, 1, 2, 0);
    gen_instr(C_AND, 1'b1, 0, 1, 0);
    gen_instr(C_XOR, 1'b0, 0, 0, 0);
    gen_instr(C_JMP, rb(), 2, 0, 0);
    gen_instr(C_LDA, 1'b1, 0, 3, 0);
    run_q("mix");
    chk("mix_done",  32'(n_done), 32'd5);
    chk("mix_ld_ac", 32'(n_ldac), 32'd4);
    chk("mix_viol",  32'(n_viol), 32'd0);

    // Reset during the OP_FETCH wait, then a clean XOR
    gen_front(C_LDA, 0);
    push(1'b0, C_LDA, rb(), 1'b0, 1'b1, 5, 1'b0);
    push(1'b0, C_LDA, rb(), 1'b0, 1'b1, 5, 1'b0);
    push(1'b1, C_LDA, rb(), 1'b1, 1'b1, 5, 1'b0);
    gen_instr(C_XOR, 1'b0, 0, 0, 0);
    run_q("rst_opf");
    chk("rst_opf_done", 32'(n_done),  32'd1);
    chk("rst_opf_when", 32'(done_at), 32'd16);

    // HLT: halted for 20 cycles, reset out, then a normal LDA
    gen_instr(C_HLT, 1'b0, 0, 0, 20);
    push(1'b1, rop(), rb(), rb(), 1'b1, 8, 1'b0);
    gen_instr(C_LDA, 1'b0, 0, 0, 0);
    run_q("hlt");
    chk("hlt_cycles", 32'(n_halt), 32'd21);
    chk("hlt_done",   32'(n_done), 32'd1);
    chk("hlt_inc",    32'(n_inc),  32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_cpu_sequencer
`default_nettype wire
